// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback write-port scheduler.
// A write op is one (register, value) pair headed for the register file.
package wb_pkg;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam int         NREG  = 15;

    typedef struct packed {
        logic [3:0]  addr;
        logic [63:0] data;
    } wb_op_t;

    // Code 15 is the "no write" marker, so any other code is a real destination.
    function automatic logic is_dst(input logic [3:0] dst);
        return dst != RNONE;
    endfunction

endpackage

// File: rtl/wb_write_scheduler_fifo.sv
// Circular FIFO of write ops with two push slots and one pop per cycle.
// push_b lands in the slot after push_a when both are set.
module wb_op_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push_a,
    input  wb_op_t                 op_a,
    input  logic                   push_b,
    input  wb_op_t                 op_b,
    input  logic                   pop,
    output wb_op_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_op_t          mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   slot_b_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   push_n_s;
    logic            pop_s;

    assign pop_s    = pop && (count_r != {CW{1'b0}});
    assign push_n_s = CW'(push_a) + CW'(push_b);
    assign slot_b_s = push_a ? (wr_ptr_r + PW'(1)) : wr_ptr_r;

    // Op storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push_a) begin
            mem_r[wr_ptr_r] <= op_a;
        end
        if (push_b) begin
            mem_r[slot_b_s] <= op_b;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + push_n_s[PW-1:0];
            rd_ptr_r <= rd_ptr_r + PW'(pop_s);
            count_r  <= count_r + push_n_s - CW'(pop_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/wb_write_scheduler.sv
// Expands writeback bundles (dstE/valE, dstM/valM) into single write ops,
// drains them one per cycle to the register file, and tracks pending writes.
module wb_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int NREG  = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      dst_e,
    input  logic [63:0]     val_e,
    input  logic [3:0]      dst_m,
    input  logic [63:0]     val_m,
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic [63:0]     rf_wdata,
    output logic [NREG-1:0] busy,
    output logic            empty
);

    import wb_pkg::*;

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]   count_s;
    logic            empty_s;
    wb_op_t          head_s;
    logic            accept_s;
    logic            e_wr_s;
    logic            m_wr_s;
    logic            push_a_s;
    logic            push_b_s;
    wb_op_t          op_a_s;
    wb_op_t          op_b_s;
    logic            pop_s;
    logic            inc_s      [NREG];
    logic            dec_s      [NREG];
    logic [CW-1:0]   cnt_next_s [NREG];
    logic [CW-1:0]   cnt_r      [NREG];
    logic [NREG-1:0] busy_r;

    // Room for a worst-case two-op bundle, judged on registered occupancy only.
    assign in_ready = (DEPTH_C - count_s) >= CW'(2);
    assign accept_s = in_valid && in_ready;

    // Same register on both ports keeps only M, as popq %rsp requires.
    assign e_wr_s = accept_s && is_dst(dst_e) && (dst_e != dst_m);
    assign m_wr_s = accept_s && is_dst(dst_m);

    // Pack surviving ops into the push slots, E ahead of M.
    always_comb begin
        push_a_s = 1'b0;
        push_b_s = 1'b0;
        op_a_s   = '{addr: dst_e, data: val_e};
        op_b_s   = '{addr: dst_m, data: val_m};
        case ({e_wr_s, m_wr_s})
            2'b11: begin
                push_a_s = 1'b1;
                push_b_s = 1'b1;
            end
            2'b10: begin
                push_a_s = 1'b1;
            end
            2'b01: begin
                push_a_s = 1'b1;
                op_a_s   = '{addr: dst_m, data: val_m};
            end
            default: begin
                push_a_s = 1'b0;
                push_b_s = 1'b0;
            end
        endcase
    end

    wb_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_a  (push_a_s),
        .op_a    (op_a_s),
        .push_b  (push_b_s),
        .op_b    (op_b_s),
        .pop     (pop_s),
        .head    (head_s),
        .count   (count_s),
        .empty   (empty_s)
    );

    // The register file commits on the same edge the head is popped.
    assign rf_we    = !empty_s && reset_n;
    assign pop_s    = rf_we;
    assign rf_waddr = empty_s ? 4'h0 : head_s.addr;
    assign rf_wdata = empty_s ? 64'h0 : head_s.data;
    assign empty    = empty_s;
    assign busy     = busy_r;

    // Next pending-write count per register; E and M never share a register here.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc_s[r]      = (push_a_s && (op_a_s.addr == 4'(r))) ||
                            (push_b_s && (op_b_s.addr == 4'(r)));
            dec_s[r]      = pop_s && (head_s.addr == 4'(r));
            cnt_next_s[r] = cnt_r[r] + CW'(inc_s[r]) - CW'(dec_s[r]);
        end
    end

    // Scoreboard state; busy is registered from the next count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= {CW{1'b0}};
            end
            busy_r <= {NREG{1'b0}};
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r]  <= cnt_next_s[r];
                busy_r[r] <= (cnt_next_s[r] != {CW{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed bench for wb_write_scheduler: a queue holds the expected write ops,
// filled on acceptance and drained as the DUT drives the write port.
module tb_wb_write_scheduler;
    import wb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  dst_e = 4'h0;
    logic [63:0] val_e = 64'h0;
    logic [3:0]  dst_m = 4'h0;
    logic [63:0] val_m = 64'h0;
    logic        in_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [14:0] busy;
    logic        empty;

    int          vectors = 0;
    int          miscompares = 0;
    int          writes = 0;
    int          w0;
    wb_op_t      sb[$];
    bit          exp_ready = 1'b1;
    logic [14:0] m_busy;
    bit          m_we;
    wb_op_t      m_op;

    wb_write_scheduler dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dst_e    (dst_e),
        .val_e    (val_e),
        .dst_m    (dst_m),
        .val_m    (val_m),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .empty    (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        dst_e = de; val_e = ve; dst_m = dm; val_m = vm;
    endtask

    task automatic send(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        drive(de, ve, dm, vm);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Expected ops enter the queue when a bundle is taken on this edge
    always @(posedge clock) begin
        if (!reset_n) begin
            sb.delete();
        end else if (in_valid && exp_ready) begin
            if (dst_e != 4'hF && dst_e != dst_m) sb.push_back('{addr: dst_e, data: val_e});
            if (dst_m != 4'hF) sb.push_back('{addr: dst_m, data: val_m});
        end
    end

    // Port monitor: compares flow control, busy and writes against the queue
    always @(negedge clock) begin
        m_busy = 15'h0;
        foreach (sb[i]) if (sb[i].addr < 4'd15) m_busy[sb[i].addr] = 1'b1;
        m_we = reset_n && (sb.size() != 0);
        exp_ready = (4 - sb.size()) >= 2;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("empty", 64'(empty), 64'(sb.size() == 0));
        check("busy", 64'(busy), 64'(m_busy));
        check("rf_we", 64'(rf_we), 64'(m_we));
        if (rf_we === 1'b1) writes++;
        if (m_we) begin
            m_op = sb.pop_front();
            check("rf_waddr", 64'(rf_waddr), 64'(m_op.addr));
            check("rf_wdata", rf_wdata, m_op.data);
        end else if (sb.size() == 0) begin
            check("idle_waddr", 64'(rf_waddr), 64'h0);
            check("idle_wdata", rf_wdata, 64'h0);
        end
        for (int r = 0; r < 15; r++) begin
            check("cnt_range", 64'(dut.cnt_r[r] <= 3'd4), 64'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with junk bundle offered
        reset_n = 1'b0;
        in_valid = 1'b1;
        drive(4'hA, 64'hDEAD_BEEF_0000_0001, 4'h2, 64'hDEAD_BEEF_0000_0002);
        repeat (2) begin
            @(negedge clock);
            check("rst_empty", 64'(empty), 64'd1);
            check("rst_we", 64'(rf_we), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        in_valid = 1'b0;

        // 2: single E op, then an empty bundle, then an M-only op
        send(4'h3, 64'h1234, 4'hF, 64'h0);
        @(negedge clock);
        check("t2_we", 64'(rf_we), 64'd1);
        check("t2_addr", 64'(rf_waddr), 64'h3);
        check("t2_data", rf_wdata, 64'h1234);
        check("t2_busy", 64'(busy), 64'h0008);
        @(negedge clock);
        check("t2_empty", 64'(empty), 64'd1);
        check("t2_busy_clr", 64'(busy), 64'h0);
        @(posedge clock); #1;
        send(4'hF, 64'h5, 4'hF, 64'h6);
        @(negedge clock);
        check("t2_none_we", 64'(rf_we), 64'd0);
        check("t2_none_empty", 64'(empty), 64'd1);
        @(posedge clock); #1;
        send(4'hF, 64'h0, 4'h9, 64'h99);
        @(negedge clock);
        check("t2_m_addr", 64'(rf_waddr), 64'h9);
        check("t2_m_data", rf_wdata, 64'h99);
        @(posedge clock); #1;

        // 3: popq-style two distinct destinations
        send(4'h4, 64'h108, 4'h0, 64'hAA);
        @(negedge clock);
        check("t3_w1_addr", 64'(rf_waddr), 64'h4);
        check("t3_w1_data", rf_wdata, 64'h108);
        check("t3_busy1", 64'(busy), 64'h0011);
        @(negedge clock);
        check("t3_w2_addr", 64'(rf_waddr), 64'h0);
        check("t3_w2_data", rf_wdata, 64'hAA);
        check("t3_busy2", 64'(busy), 64'h0001);
        @(negedge clock);
        check("t3_empty", 64'(empty), 64'd1);
        @(posedge clock); #1;

        // 4: same destination on both ports, M wins
        send(4'h4, 64'h108, 4'h4, 64'h55);
        @(negedge clock);
        check("t4_addr", 64'(rf_waddr), 64'h4);
        check("t4_data", rf_wdata, 64'h55);
        check("t4_busy", 64'(busy), 64'h0010);
        @(negedge clock);
        check("t4_we_after", 64'(rf_we), 64'd0);
        check("t4_busy_after", 64'(busy), 64'h0);
        @(posedge clock); #1;

        // 5: three back-to-back two-op bundles, second straddles the wrap
        w0 = writes;
        in_valid = 1'b1;
        drive(4'h1, 64'h101, 4'h2, 64'h102);
        @(negedge clock);
        check("t5_ready_c0", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        drive(4'h3, 64'h103, 4'h8, 64'h108);
        @(negedge clock);
        check("t5_ready_c1", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        drive(4'h6, 64'h106, 4'h7, 64'h107);
        @(negedge clock);
        check("t5_ready_c2", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("t5_ready_c3", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("t5_write_count", 64'(writes - w0), 64'd6);
        @(negedge clock);
        check("t5_empty", 64'(empty), 64'd1);
        @(posedge clock); #1;

        // 6: reset with three ops queued, two of them to r5
        in_valid = 1'b1;
        drive(4'h6, 64'hA, 4'h5, 64'hB);
        @(posedge clock); #1;
        drive(4'h5, 64'hC, 4'h7, 64'hD);
        @(negedge clock);
        check("t6_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        check("t6_we_in_reset", 64'(rf_we), 64'd0);
        check("t6_busy_pre", 64'(busy), 64'h00A0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("t6_empty_post", 64'(empty), 64'd1);
        check("t6_busy_post", 64'(busy), 64'h0);
        repeat (4) begin
            @(negedge clock);
            check("t6_no_residual", 64'(rf_we), 64'd0);
        end
        @(posedge clock); #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
